// File: rtl/leds_nios2_cpu_debug_scan_master.sv
// Virtual-JTAG scan master: one UIR/CDR/SDR/UDR/RTI sequence per command, tck generated from clk.
// Optional macro LEDS_NIOS2_DEBUG_SCAN_CAPTURE_EN builds the vji_tdo capture register.
module leds_nios2_cpu_debug_scan_master #(
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2,
  parameter int SR_WIDTH   = 38
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_ir_i,
  input  logic [SR_WIDTH-1:0] cmd_data_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [SR_WIDTH-1:0] resp_data_o,
  output logic                vji_tck_o,
  output logic                vji_tdi_o,
  output logic                vji_rti_o,
  output logic                vji_uir_o,
  output logic                vji_cdr_o,
  output logic                vji_sdr_o,
  output logic                vji_udr_o,
  output logic [1:0]          vji_ir_in_o,
  input  logic                vji_tdo_i
);
  localparam int PW = 9;
  localparam int CW = $clog2(SR_WIDTH + 16);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP} state_e;

  state_e                state_q;
  logic [PW-1:0]         ph_q;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            ir_q;
  logic [SR_WIDTH-1:0]   sh_q;
  logic                  pend, rise, in_scan;

  // ph_q walks one tck period: low half first, high half second
  assign pend    = (ph_q == PW'(2*TCK_DIV - 1));
  assign rise    = (ph_q == PW'(TCK_DIV));
  assign in_scan = (state_q != S_IDLE) && (state_q != S_RESP);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      sh_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ph_q <= '0;
          if (cmd_valid_i) begin
            ir_q    <= cmd_ir_i;
            sh_q    <= cmd_data_i;
            state_q <= S_UIR;
          end
        end
        S_RESP: begin
          ph_q <= '0;
          if (resp_ready_i) state_q <= S_IDLE;
        end
        default: begin
          ph_q <= pend ? '0 : ph_q + 1'b1;
          if (pend) begin
            case (state_q)
              S_UIR: state_q <= S_CDR;
              S_CDR: begin
                state_q <= S_SDR;
                cnt_q   <= '0;
              end
              S_SDR: begin
                // shift at period end so tdi changes only as tck falls
                sh_q <= sh_q >> 1;
                if (cnt_q == CW'(SR_WIDTH - 1)) state_q <= S_UDR;
                else                            cnt_q   <= cnt_q + 1'b1;
              end
              S_UDR: begin
                cnt_q   <= '0;
                state_q <= (RTI_CYCLES == 0) ? S_RESP : S_RTI;
              end
              S_RTI: begin
                if (cnt_q == CW'(RTI_CYCLES - 1)) state_q <= S_RESP;
                else                              cnt_q   <= cnt_q + 1'b1;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign vji_tck_o    = in_scan && (ph_q >= PW'(TCK_DIV));
  assign vji_tdi_o    = (state_q == S_SDR) && sh_q[0];
  assign vji_uir_o    = (state_q == S_UIR);
  assign vji_cdr_o    = (state_q == S_CDR);
  assign vji_sdr_o    = (state_q == S_SDR);
  assign vji_udr_o    = (state_q == S_UDR);
  assign vji_rti_o    = (state_q == S_RTI);
  assign vji_ir_in_o  = ir_q;

`ifdef LEDS_NIOS2_DEBUG_SCAN_CAPTURE_EN
  logic [SR_WIDTH-1:0] cap_q;

  // first bit captured ends up at bit 0 after SR_WIDTH shifts
  always_ff @(posedge clk_i) begin
    if (reset_i)                        cap_q <= '0;
    else if (state_q == S_SDR && rise)  cap_q <= {vji_tdo_i, cap_q[SR_WIDTH-1:1]};
  end

  assign resp_data_o = cap_q;
`else
  logic unused_tdo;
  logic unused_rise;
  assign unused_tdo  = vji_tdo_i;
  assign unused_rise = rise;
  assign resp_data_o = '0;
`endif

endmodule

// File: tb/tb_leds_nios2_cpu_debug_scan_master.sv
// Directed bench: default instance (a) and TCK_DIV=1/RTI_CYCLES=0 instance (b) share command inputs.
module tb_leds_nios2_cpu_debug_scan_master;
  localparam int W = 38;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [1:0]   cmd_ir;
  logic [W-1:0] cmd_data;
  logic         resp_ready;
  logic         a_tie1;
  logic         sel;

  logic         a_ready, a_rv, a_tck, a_tdi, a_rti, a_uir, a_cdr, a_sdr, a_udr, a_tdo;
  logic [1:0]   a_ir;
  logic [W-1:0] a_rd;
  logic         b_ready, b_rv, b_tck, b_tdi, b_rti, b_uir, b_cdr, b_sdr, b_udr, b_tdo;
  logic [1:0]   b_ir;
  logic [W-1:0] b_rd;

  int n_chk = 0;
  int n_err = 0;

`ifdef LEDS_NIOS2_DEBUG_SCAN_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  always #5 clk = ~clk;

  assign a_tdo = a_tie1 ? 1'b1 : a_tdi;
  assign b_tdo = b_tdi;

  leds_nios2_cpu_debug_scan_master u_a (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(a_ready),
    .cmd_ir_i(cmd_ir), .cmd_data_i(cmd_data), .resp_valid_o(a_rv), .resp_ready_i(resp_ready),
    .resp_data_o(a_rd), .vji_tck_o(a_tck), .vji_tdi_o(a_tdi), .vji_rti_o(a_rti),
    .vji_uir_o(a_uir), .vji_cdr_o(a_cdr), .vji_sdr_o(a_sdr), .vji_udr_o(a_udr),
    .vji_ir_in_o(a_ir), .vji_tdo_i(a_tdo));

  leds_nios2_cpu_debug_scan_master #(.TCK_DIV(1), .RTI_CYCLES(0)) u_b (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(b_ready),
    .cmd_ir_i(cmd_ir), .cmd_data_i(cmd_data), .resp_valid_o(b_rv), .resp_ready_i(resp_ready),
    .resp_data_o(b_rd), .vji_tck_o(b_tck), .vji_tdi_o(b_tdi), .vji_rti_o(b_rti),
    .vji_uir_o(b_uir), .vji_cdr_o(b_cdr), .vji_sdr_o(b_sdr), .vji_udr_o(b_udr),
    .vji_ir_in_o(b_ir), .vji_tdo_i(b_tdo));

  logic         m_rv, m_tck, m_rti, m_uir, m_cdr, m_sdr, m_udr;
  logic [1:0]   m_ir;
  assign m_rv  = sel ? b_rv  : a_rv;
  assign m_tck = sel ? b_tck : a_tck;
  assign m_rti = sel ? b_rti : a_rti;
  assign m_uir = sel ? b_uir : a_uir;
  assign m_cdr = sel ? b_cdr : a_cdr;
  assign m_sdr = sel ? b_sdr : a_sdr;
  assign m_udr = sel ? b_udr : a_udr;
  assign m_ir  = sel ? b_ir  : a_ir;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    cmd_valid  = 1'b0;
    resp_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // drive one command through the acceptance edge; caller decides whether valid stays high
  task automatic accept(input logic [1:0] ir, input logic [W-1:0] d, input bit hold);
    cmd_ir    = ir;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output int sdr_n, output int rises, output int rti_n,
                           output int uir_n, output int multi, output logic [1:0] ir_uir);
    bit prev, done;
    lat = 0; sdr_n = 0; rises = 0; rti_n = 0; uir_n = 0; multi = 0; ir_uir = 2'b00;
    done = 1'b0;
    prev = m_tck;
    while (!done && lat < 2000) begin
      if (m_sdr) sdr_n++;
      if (m_rti) rti_n++;
      if (m_uir) begin
        if (uir_n == 0) ir_uir = m_ir;
        uir_n++;
      end
      if (m_sdr && m_tck && !prev) rises++;
      if ($countones({m_rti, m_uir, m_cdr, m_sdr, m_udr}) > 1) multi++;
      prev = m_tck;
      tick();
      lat++;
      if (m_rv) done = 1'b1;
    end
    check("resp_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int lat, sdr_n, rises, rti_n, uir_n, multi, rv_seen, bad;
    logic [1:0]   ir_uir;
    logic [W-1:0] hold_d;

    rst = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0;
    resp_ready = 1'b0; a_tie1 = 1'b0; sel = 1'b0;

    // reset state
    reset_all();
    check("rst_ready",  64'(a_ready), 64'd1);
    check("rst_rv",     64'(a_rv),    64'd0);
    check("rst_vji",    64'({a_tck, a_tdi, a_rti, a_uir, a_cdr, a_sdr, a_udr}), 64'd0);
    check("rst_ir",     64'(a_ir),    64'd0);
    check("rst_rd",     64'(a_rd),    64'd0);
    check("rst_b_vji",  64'({b_tck, b_tdi, b_rti, b_uir, b_cdr, b_sdr, b_udr, b_rv}), 64'd0);

    // stray resp_ready in IDLE does nothing
    resp_ready = 1'b1;
    tick(); tick();
    resp_ready = 1'b0;
    check("idle_rr_ready", 64'(a_ready), 64'd1);
    check("idle_rr_rv",    64'(a_rv),    64'd0);

    // loopback scan, defaults
    reset_all();
    sel = 1'b0; a_tie1 = 1'b0;
    accept(2'b01, 38'h0_DEAD_BEEF, 1'b0);
    wait_resp(lat, sdr_n, rises, rti_n, uir_n, multi, ir_uir);
    check("lb_latency", 64'(lat), 64'd172);
    check("lb_data",    64'(a_rd), CAP ? 64'h0_DEAD_BEEF : 64'd0);
    check("lb_ir",      64'(ir_uir), 64'd1);
    check("lb_onehot",  64'(multi), 64'd0);
    check("lb_uir_n",   64'(uir_n), 64'd4);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("lb_back_ready", 64'(a_ready), 64'd1);
    check("lb_back_rv",    64'(a_rv),    64'd0);
    check("lb_ir_held",    64'(a_ir),    64'd1);

    // tdo tied high, zero data
    reset_all();
    a_tie1 = 1'b1;
    accept(2'b11, '0, 1'b0);
    wait_resp(lat, sdr_n, rises, rti_n, uir_n, multi, ir_uir);
    check("t1_data",  64'(a_rd), CAP ? 64'h3F_FFFF_FFFF : 64'd0);
    check("t1_sdr",   64'(sdr_n), 64'd152);
    check("t1_rises", 64'(rises), 64'd38);
    check("t1_rti",   64'(rti_n), 64'd8);
    check("t1_lat",   64'(lat),   64'd172);
    a_tie1 = 1'b0;

    // fast tck, no RTI
    reset_all();
    sel = 1'b1;
    accept(2'b10, 38'h15_0F0F_3C3C, 1'b0);
    wait_resp(lat, sdr_n, rises, rti_n, uir_n, multi, ir_uir);
    check("f_latency", 64'(lat),    64'd82);
    check("f_ir",      64'(ir_uir), 64'd2);
    check("f_rti",     64'(rti_n),  64'd0);
    check("f_sdr",     64'(sdr_n),  64'd76);
    check("f_rises",   64'(rises),  64'd38);
    check("f_data",    64'(b_rd), CAP ? 64'h15_0F0F_3C3C : 64'd0);
    sel = 1'b0;

    // reset during SDR bit 10
    reset_all();
    accept(2'b01, 38'h2A_1234_5678, 1'b0);
    lat = 0;
    while (!a_sdr && lat < 100) begin tick(); lat++; end
    check("mid_sdr_reached", 64'(a_sdr), 64'd1);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_vji",   64'({a_tck, a_tdi, a_rti, a_uir, a_cdr, a_sdr, a_udr}), 64'd0);
    check("mid_ir",    64'(a_ir),    64'd0);
    check("mid_ready", 64'(a_ready), 64'd1);
    check("mid_rv",    64'(a_rv),    64'd0);
    rv_seen = 0;
    repeat (200) begin tick(); if (a_rv) rv_seen++; end
    check("mid_no_resp", 64'(rv_seen), 64'd0);
    accept(2'b01, 38'h2A_1234_5678, 1'b0);
    wait_resp(lat, sdr_n, rises, rti_n, uir_n, multi, ir_uir);
    check("mid_next_lat",  64'(lat),  64'd172);
    check("mid_next_data", 64'(a_rd), CAP ? 64'h2A_1234_5678 : 64'd0);

    // response back-pressure with cmd_valid held high throughout
    reset_all();
    accept(2'b00, 38'h2A_5555_AAAA, 1'b1);
    wait_resp(lat, sdr_n, rises, rti_n, uir_n, multi, ir_uir);
    check("bp_lat", 64'(lat), 64'd172);
    hold_d = a_rd;
    bad = 0;
    repeat (20) begin
      tick();
      if (a_rd !== hold_d || a_ready !== 1'b0 || a_rv !== 1'b1) bad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_data",   64'(a_rd), CAP ? 64'h2A_5555_AAAA : 64'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    cmd_valid  = 1'b0;
    check("bp_ready_after", 64'(a_ready), 64'd1);
    check("bp_rv_after",    64'(a_rv),    64'd0);
    tick();
    check("bp_no_queue", 64'({a_uir, a_rv, a_ready}), 64'b001);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/leds_nios2_cpu_debug_scan_master.md
LEDS_NIOS2_CPU_DEBUG_SCAN_MASTER -- requirements
Module: leds_nios2_cpu_debug_scan_master

Interface
REQ-001 The block SHALL have parameter TCK_DIV, default 2, meaning clk cycles per vji_tck half-period (legal 1..255).
REQ-002 The block SHALL have parameter RTI_CYCLES, default 2, meaning tck periods spent in run-test-idle after each scan (legal 0..15).
REQ-003 The block SHALL have parameter SR_WIDTH, default 38, meaning DR scan length in bits.
REQ-004 clk  input  1  system clock; the block uses one clock only.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 cmd_valid  input  1  scan request valid.
REQ-007 cmd_ready  output  1  scan request accepted on a clk edge where cmd_valid=1.
REQ-008 cmd_ir  input  2  virtual IR value for this scan.
REQ-009 cmd_data  input  SR_WIDTH  DR value shifted in, LSB first.
REQ-010 resp_valid  output  1  scan complete; resp_data valid.
REQ-011 resp_ready  input  1  response consumed on a clk edge where resp_valid=1.
REQ-012 resp_data  output  SR_WIDTH  bits captured from vji_tdo, LSB first.
REQ-013 vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr  output  1 each  virtual JTAG drive toward the debug slave.
REQ-014 vji_ir_in  output  2  virtual IR toward the debug slave.
REQ-015 vji_tdo  input  1  serial data returned by the debug slave.

Function
REQ-016 A tck period SHALL be 2*TCK_DIV clk cycles: vji_tck low for the first TCK_DIV cycles ("fall"), high for the last TCK_DIV cycles ("rise").
REQ-017 States SHALL be IDLE, UIR, CDR, SDR, UDR, RTI, RESP; every state other than IDLE and RESP lasts whole tck periods; vji_tck is held 0 in IDLE and RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; acceptance latches cmd_ir/cmd_data and moves to UIR on the next cycle.
REQ-019 UIR: 1 period, vji_uir=1, vji_ir_in loaded with cmd_ir at period start and held until the next UIR.
REQ-020 CDR: 1 period, vji_cdr=1.
REQ-021 SDR: SR_WIDTH periods, vji_sdr=1; vji_tdi changes only at period start (falling tck) and carries data bit k in period k; vji_tdo is sampled on the clk cycle that vji_tck rises.
REQ-022 UDR: 1 period, vji_udr=1; then RTI for RTI_CYCLES periods with vji_rti=1 (skipped if RTI_CYCLES=0).
REQ-023 At most one of vji_uir/cdr/sdr/udr/rti SHALL be 1 in any cycle.
REQ-024 resp_valid SHALL assert the clk cycle after the last period ends and hold, with resp_data stable, until the resp_ready edge; the block then returns to IDLE.
REQ-025 Latency acceptance-edge to resp_valid SHALL be exactly (SR_WIDTH+3+RTI_CYCLES)*2*TCK_DIV clk cycles (172 with defaults).
REQ-026 cmd_valid asserted outside IDLE SHALL be ignored; no command is queued.
REQ-027 resp_ready asserted without resp_valid SHALL have no effect.

Reset
REQ-028 reset=1 at any clk edge, including mid-scan, SHALL force IDLE next cycle, abandon the scan without a response, and drive all outputs 0 except cmd_ready=1.
REQ-029 Reset values: vji_* outputs 0, vji_ir_in 2'b00, resp_valid 0, resp_data 0.

Configuration
REQ-030 With macro LEDS_NIOS2_DEBUG_SCAN_CAPTURE_EN defined, resp_data SHALL hold the captured vji_tdo bits per REQ-021.
REQ-031 Without LEDS_NIOS2_DEBUG_SCAN_CAPTURE_EN, vji_tdo SHALL be ignored, resp_data SHALL be constant 0 and no capture register is built; timing and handshakes are unchanged.

Verification
REQ-032 Loopback vji_tdo=vji_tdi, defaults, cmd_ir=2'b01, cmd_data=38'h0_DEAD_BEEF -> resp_valid at cycle 172, resp_data=38'h0_DEAD_BEEF (capture on).
REQ-033 vji_tdo tied 1, cmd_data=0 -> resp_data=38'h3F_FFFF_FFFF; vji_sdr high exactly 152 cycles; 38 tck rises counted in SDR.
REQ-034 TCK_DIV=1, RTI_CYCLES=0, cmd_ir=2'b10 -> vji_ir_in=2'b10 from UIR start, latency 82 cycles, vji_rti never 1.
REQ-035 reset pulsed 1 cycle at SDR bit 10 -> next cycle all vji_* 0, cmd_ready=1, no resp_valid; next command completes normally.
REQ-036 resp_ready held 0 for 20 cycles after resp_valid, cmd_valid held 1 throughout -> resp_data stable, cmd_ready 0 until the cycle after resp_ready accepted.
